crc32_stream: RTL
=================

Name: crc32_stream

Overview:
Parametrised streaming CRC-32 generator/checker, the successor to the 8-bit crc32 block. It accepts DATA_W-bit beats under a valid/ready handshake with frame delimiters and a partial last beat. It passes the data through one register stage and reports a per-frame CRC (generate mode) or a pass/fail residue check (check mode). It sits in the MAC datapath between the framer and the TX/RX FIFOs.

Parameters:
DATA_W, 32, beat width in bits; multiple of 8, range 8..64; BYTES = DATA_W/8
POLY, 32'h04C11DB7, generator polynomial, normal (MSB-first) form
INIT, 32'hFFFFFFFF, CRC register value at start of frame
XOR_OUT, 32'hFFFFFFFF, XOR applied to the register to form crc_value
REFLECT, 1, 1 = bits within each byte processed LSB first and result bit-reversed (Ethernet); 0 = MSB first, no reversal
RESIDUE, 32'hDEBB20E3, register value (before XOR_OUT) that indicates a good frame in check mode
MTY_W, max(1,clog2(BYTES)), width of the empty-byte count

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
in_data  in  DATA_W  beat data; byte 0 = in_data[7:0] is first on the wire
in_valid  in  1  beat valid
in_ready  out  1  block can accept a beat
in_sop  in  1  first beat of frame
in_eop  in  1  last beat of frame
in_mty  in  MTY_W  number of unused top bytes on the eop beat; ignored otherwise; must be < BYTES
check_mode  in  1  sampled on the sop beat: 0 = generate, 1 = check
out_data/out_sop/out_eop/out_mty  out  DATA_W/1/1/MTY_W  registered copy of the input beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
crc_value  out  32  final CRC of the last completed frame (register ^ XOR_OUT, reflected per REFLECT)
crc_valid  out  1  one-cycle pulse: crc_value/crc_ok updated
crc_ok  out  1  check mode: register == RESIDUE at eop; generate mode: forced 1
seq_err  out  1  one-cycle pulse on a framing violation

Behaviour:
- Reset: all outputs 0 except crc_value = 0; CRC register = INIT; state IDLE.
- Handshake: in_ready = ~out_valid | out_ready (single pipeline register, no combinational path from in_valid). A beat is accepted when in_valid & in_ready. Accepted beats are copied to out_* on the next edge. out_valid is held with stable data until out_ready. A beat is never dropped or duplicated; throughput is 1 beat/cycle when out_ready = 1.
- CRC update: byte-serial LFSR unrolled over the valid bytes of the beat, in order byte 0..BYTES-1. Bytes >= BYTES-in_mty on the eop beat are excluded. It is one combinational stage from the register; no multicycle paths.
- State machine:
  - IDLE + sop beat: reg <= update(INIT, beat); latch check_mode; -> ACTIVE. If eop is also set (single-beat frame), finish immediately and stay in IDLE.
  - ACTIVE + non-sop beat: reg <= update(reg, beat). On eop, finish -> IDLE.
  - finish: crc_valid pulses the cycle after the eop handshake, coincident with the first cycle out_eop is presented. crc_value and crc_ok hold until the next finish. reg <= INIT.
  - ACTIVE + sop beat: seq_err pulse; the previous frame is aborted with no crc_valid; restart from INIT with this beat.
  - IDLE + non-sop beat: seq_err pulse; the beat is passed through but excluded from the CRC; no crc_valid.
- No valid beat, or a beat stalled by backpressure: register and state unchanged.
- in_mty >= BYTES on eop: treated as BYTES-1 (one byte used); no error flag.
- check_mode changing mid-frame has no effect until the next sop.
- Reset mid-frame: immediate abort; no crc_valid; out_valid drops to 0.

Test Plan:
- DATA_W=8, generate, "123456789" (0x31..0x39), sop on 0x31, eop on 0x39 -> crc_valid once, crc_value=32'hCBF43926, crc_ok=1; out stream identical to input, 1-cycle latency.
- DATA_W=32, beats 32'h34333231, 32'h38373635, 32'h00000039 with eop and mty=3 -> crc_value=32'hCBF43926; repeat with a single-beat frame 32'h34333231 (sop+eop, mty=0) and compare against a reference model.
- Check mode, DATA_W=32, "123456789" followed by 0x26,0x39,0xF4,0xCB (13 bytes, last beat mty=3) -> crc_ok=1; flip one bit of the data -> crc_ok=0.
- Backpressure: random out_ready (~50% duty) over 20 random frames -> output stream equals input and crc results match the model; in_ready never high while out_valid & ~out_ready.
- Framing errors: sop mid-frame -> seq_err pulse, no crc_valid for the aborted frame, and the new frame's CRC is correct; a beat with no sop while IDLE -> seq_err pulse, data passed through.
- Assert reset during beat 2 of a 3-beat frame, then send a fresh "123456789" frame -> outputs at reset values, then crc_value=32'hCBF43926.

Source files
------------

// File: rtl/crc32_stream.sv
// Streaming CRC-32 generator/checker.
// DATA_W-bit beats pass through one register stage under valid/ready. The CRC
// register is advanced by a chain of per-byte LFSR stages, one per byte lane,
// over the valid bytes of each accepted beat. At end of frame the block
// reports the final CRC (generate mode) or a residue check (check mode).

// One byte of CRC-32 LFSR update; passes crc_i through unchanged when en_i=0.
// With REFLECT=1 the register is kept in reflected (LSB-first) orientation, so
// the final value needs no bit reversal and the good-frame residue is the
// familiar Ethernet constant.
module crc32_stream_byte #(
  parameter logic [31:0] POLY    = 32'h04C11DB7,
  parameter bit          REFLECT = 1'b1
) (
  input  logic [31:0] crc_i,
  input  logic [7:0]  byte_i,
  input  logic        en_i,
  output logic [31:0] crc_o
);

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  localparam logic [31:0] RPOLY = rev32(POLY);

  // Eight unrolled shift/xor steps, bit order chosen by REFLECT.
  always_comb begin
    logic [31:0] c;
    c = crc_i;
    for (int b = 0; b < 8; b++) begin
      if (REFLECT) begin
        if (c[0] ^ byte_i[b]) c = (c >> 1) ^ RPOLY;
        else                  c = c >> 1;
      end else begin
        if (c[31] ^ byte_i[7-b]) c = (c << 1) ^ POLY;
        else                     c = c << 1;
      end
    end
    crc_o = en_i ? c : crc_i;
  end

endmodule

module crc32_stream #(
  parameter int          DATA_W  = 32,
  parameter logic [31:0] POLY    = 32'h04C11DB7,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT = 32'hFFFFFFFF,
  parameter bit          REFLECT = 1'b1,
  parameter logic [31:0] RESIDUE = 32'hDEBB20E3,
  parameter int          MTY_W   = ((DATA_W / 8) > 1) ? $clog2(DATA_W / 8) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [MTY_W-1:0]  in_mty,
  input  logic              check_mode,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic [MTY_W-1:0]  out_mty,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       crc_value,
  output logic              crc_valid,
  output logic              crc_ok,
  output logic              seq_err
);

  localparam int BYTES = DATA_W / 8;

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [31:0]         crc_q, crc_d;
  logic                mode_q, mode_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_sop_q, out_sop_d;
  logic                out_eop_q, out_eop_d;
  logic [MTY_W-1:0]    out_mty_q, out_mty_d;
  logic                out_valid_q, out_valid_d;
  logic [31:0]         crc_value_q, crc_value_d;
  logic                crc_valid_q, crc_valid_d;
  logic                crc_ok_q, crc_ok_d;
  logic                seq_err_q, seq_err_d;

  logic                accept;
  logic [BYTES-1:0]    byte_en;
  int                  nbytes;
  logic [31:0]         crc_base;
  logic [31:0]         crc_upd;

  // Single register stage: a new beat may enter whenever the slot is empty
  // or is being drained this cycle. Never depends on in_valid.
  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  // A sop beat always starts from INIT, which also covers the abort/restart
  // case when a sop arrives mid-frame.
  assign crc_base = in_sop ? INIT : crc_q;

  // Byte lanes in use: all of them, except on eop where the top in_mty are
  // empty. An out-of-range count still keeps one byte.
  always_comb begin
    nbytes = BYTES;
    if (in_eop) begin
      if (int'(in_mty) >= BYTES) nbytes = 1;
      else                       nbytes = BYTES - int'(in_mty);
    end
    for (int i = 0; i < BYTES; i++) byte_en[i] = (i < nbytes);
  end

  // Byte-lane LFSR chain, lane 0 first (first on the wire).
  for (genvar g = 0; g < BYTES; g++) begin : g_byte
    logic [31:0] c_in;
    logic [31:0] c_out;
    if (g == 0) begin : g_first
      assign c_in = crc_base;
    end else begin : g_next
      assign c_in = g_byte[g-1].c_out;
    end
    crc32_stream_byte #(
      .POLY    (POLY),
      .REFLECT (REFLECT)
    ) u_byte (
      .crc_i  (c_in),
      .byte_i (in_data[8*g +: 8]),
      .en_i   (byte_en[g]),
      .crc_o  (c_out)
    );
  end

  assign crc_upd = g_byte[BYTES-1].c_out;

  // Next-state: pass-through register, framing FSM, CRC register and results.
  always_comb begin
    logic finish;
    logic fin_mode;
    state_d     = state_q;
    crc_d       = crc_q;
    mode_d      = mode_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_mty_d   = out_mty_q;
    out_valid_d = out_valid_q & ~out_ready;
    crc_value_d = crc_value_q;
    crc_ok_d    = crc_ok_q;
    crc_valid_d = 1'b0;
    seq_err_d   = 1'b0;
    finish      = 1'b0;
    fin_mode    = mode_q;

    if (accept) begin
      out_data_d  = in_data;
      out_sop_d   = in_sop;
      out_eop_d   = in_eop;
      out_mty_d   = in_mty;
      out_valid_d = 1'b1;

      if (in_sop) begin
        // sop while a frame is open aborts that frame silently apart from
        // the error pulse; the mode is taken fresh from this beat.
        seq_err_d = (state_q == S_ACTIVE);
        mode_d    = check_mode;
        fin_mode  = check_mode;
        if (in_eop) begin
          finish = 1'b1;
        end else begin
          state_d = S_ACTIVE;
          crc_d   = crc_upd;
        end
      end else if (state_q == S_ACTIVE) begin
        if (in_eop) finish = 1'b1;
        else        crc_d  = crc_upd;
      end else begin
        // Stray beat outside a frame: forwarded, not folded into any CRC.
        seq_err_d = 1'b1;
      end
    end

    if (finish) begin
      state_d     = S_IDLE;
      crc_d       = INIT;
      crc_valid_d = 1'b1;
      // Register orientation already matches the output bit order.
      crc_value_d = crc_upd ^ XOR_OUT;
      crc_ok_d    = fin_mode ? (crc_upd == RESIDUE) : 1'b1;
    end
  end

  // State and output registers; reset aborts any open frame immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      crc_q       <= INIT;
      mode_q      <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_mty_q   <= '0;
      out_valid_q <= 1'b0;
      crc_value_q <= '0;
      crc_valid_q <= 1'b0;
      crc_ok_q    <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      mode_q      <= mode_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_mty_q   <= out_mty_d;
      out_valid_q <= out_valid_d;
      crc_value_q <= crc_value_d;
      crc_valid_q <= crc_valid_d;
      crc_ok_q    <= crc_ok_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_mty   = out_mty_q;
  assign out_valid = out_valid_q;
  assign crc_value = crc_value_q;
  assign crc_valid = crc_valid_q;
  assign crc_ok    = crc_ok_q;
  assign seq_err   = seq_err_q;

endmodule
